apb4_eg_reg_arbiter: RTL and testbench
======================================

APB4_EG_REG_ARBITER -- requirements
Module: apb4_eg_reg_arbiter

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 12, width of the register-block byte address.
REQ-002 SHALL have port pclk, input, 1, clock; all state changes on its rising edge.
REQ-003 SHALL have port presetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req, input, 2, per-requester access request; bit n belongs to requester n.
REQ-005 SHALL have port req_we, input, 2, per-requester direction: 1 = write, 0 = read.
REQ-006 SHALL have port req_addr, input, 2*ADDRWIDTH, per-requester byte address; requester n uses slice [n*ADDRWIDTH +: ADDRWIDTH].
REQ-007 SHALL have port req_strb, input, 8, per-requester byte strobes; requester n uses [n*4 +: 4].
REQ-008 SHALL have port req_wdata, input, 64, per-requester write data; requester n uses [n*32 +: 32].
REQ-009 SHALL have port ack, output, 2, one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port req_rdata, output, 32, read data returned to requesters; valid while ack is high.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-012 SHALL have port addr, output, ADDRWIDTH, address to the register block.
REQ-013 SHALL have port read_en, output, 1, register-block read enable.
REQ-014 SHALL have port write_en, output, 1, register-block write enable.
REQ-015 SHALL have port byte_strobe, output, 4, register-block byte enables.
REQ-016 SHALL have port wdata, output, 32, register-block write data.
REQ-017 SHALL have port rdata, input, 32, combinational read data from the register block.

Function
REQ-018 SHALL implement the FSM IDLE -> SETUP -> ACCESS -> DONE -> IDLE; each state lasts exactly one cycle except IDLE.
REQ-019 SHALL, in IDLE with any req bit high, choose a winner and latch its we, addr, strb and wdata, then enter SETUP on the next edge.
REQ-020 SHALL drive addr, byte_strobe and wdata from the latched fields in SETUP and ACCESS, with read_en and write_en low in SETUP.
REQ-021 SHALL, in ACCESS, assert exactly one cycle of write_en (latched we = 1) or read_en (latched we = 0); byte_strobe SHALL be 0 for reads.
REQ-022 SHALL capture rdata into req_rdata at the end of a read ACCESS; req_rdata SHALL hold its value on writes and when idle.
REQ-023 SHALL pulse ack[winner] for the single DONE cycle; ack SHALL never have both bits high.
REQ-024 SHALL give a latency of exactly 3 cycles from req sampled high in IDLE to ack high.
REQ-025 SHALL use round-robin arbitration on simultaneous requests, granting the requester not granted last; a lone request SHALL always win.
REQ-026 SHALL complete a granted transaction even if the requester drops req after the grant, since all fields are latched at grant.
REQ-027 SHALL re-arbitrate in IDLE for a requester that holds req high through ack, giving one transaction per grant and a 4-cycle repeat period.
REQ-028 SHALL still assert write_en for a write with strobe 4'b0000, leaving the register contents unchanged.
REQ-029 SHALL drive addr, wdata and byte_strobe to 0 in IDLE and DONE.

Reset
REQ-030 SHALL, while presetn is low, force state IDLE, ack = 0, busy = 0, read_en = 0, write_en = 0, addr = 0, byte_strobe = 0, wdata = 0, req_rdata = 0, and set the last-grant pointer to requester 1.
REQ-031 SHALL abort an in-flight transaction on reset with no ack issued; the first arbitration after reset favours requester 0.

Configuration
REQ-032 SHALL, with macro APB4_EG_ARB_FIXED_PRIO_EN defined, always grant requester 0 on simultaneous requests and ignore the last-grant pointer.
REQ-033 SHALL, without APB4_EG_ARB_FIXED_PRIO_EN, use the round-robin arbitration of REQ-025.

Verification
REQ-034 SHALL check: after reset, requester 0 writes addr 0x000, strb 4'b0011, wdata 0xAABBCCDD, then reads 0x000 -> write_en for exactly one cycle, ack[0] at +3 cycles, read returns req_rdata = 0x0000CCDD.
REQ-035 SHALL check: req = 2'b11 held high with reads of 0xFD0 and 0xFF4 -> grants alternate 0,1,0,1 with req_rdata 0x00000004 on ack[0] and 0x000000F0 on ack[1].
REQ-036 SHALL check: same stimulus as REQ-035 with APB4_EG_ARB_FIXED_PRIO_EN defined -> only ack[0] pulses while both requests stay high.
REQ-037 SHALL check: presetn pulsed low during ACCESS of a write to 0x004 -> enables drop immediately, no ack, busy = 0, FSM in IDLE.
REQ-038 SHALL check: requester 1 drops req one cycle after grant on a write of 0x12345678 to 0x008 -> write completes, ack[1] pulses, a later read of 0x008 returns 0x12345678.

Source files
------------

// File: rtl/apb4_eg_reg_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a register block.
// The slave modport is the arbiter's view; the master modport is the requester/register-block side.
interface apb4_eg_reg_arbiter_if #(
    parameter int unsigned ADDRWIDTH = 12
) ();
    logic [1:0]             req;
    logic [1:0]             req_we;
    logic [2*ADDRWIDTH-1:0] req_addr;
    logic [7:0]             req_strb;
    logic [63:0]            req_wdata;
    logic [1:0]             ack;
    logic [31:0]            req_rdata;
    logic                   busy;
    logic [ADDRWIDTH-1:0]   addr;
    logic                   read_en;
    logic                   write_en;
    logic [3:0]             byte_strobe;
    logic [31:0]            wdata;
    logic [31:0]            rdata;

    modport slave (
        input  req, req_we, req_addr, req_strb, req_wdata, rdata,
        output ack, req_rdata, busy, addr, read_en, write_en, byte_strobe, wdata
    );

    modport master (
        output req, req_we, req_addr, req_strb, req_wdata, rdata,
        input  ack, req_rdata, busy, addr, read_en, write_en, byte_strobe, wdata
    );
endinterface

// File: rtl/apb4_eg_reg_arbiter.sv
// Two-requester arbiter driving a register block through an IDLE/SETUP/ACCESS/DONE sequence.
// Define APB4_EG_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority to requester 0.
module apb4_eg_reg_arbiter #(
    parameter int unsigned ADDRWIDTH = 12
) (
    input logic                  pclk,
    input logic                  presetn,
    apb4_eg_reg_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic                   we_q, we_d;
    logic [ADDRWIDTH-1:0]   addr_q, addr_d;
    logic [3:0]             strb_q, strb_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   grant_q, grant_d;
    logic                   last_q, last_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   winner;

    always_comb begin
        winner = 1'b0;
        case (bus.req)
            2'b10:   winner = 1'b1;
            2'b11: begin
`ifdef APB4_EG_ARB_FIXED_PRIO_EN
                winner = 1'b0;
`else
                // Favour whoever did not win the previous grant.
                winner = ~last_q;
`endif
            end
            default: winner = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        strb_d  = strb_q;
        wdata_d = wdata_q;
        grant_d = grant_q;
        last_d  = last_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    state_d = StSetup;
                    grant_d = winner;
                    last_d  = winner;
                    we_d    = bus.req_we[winner];
                    addr_d  = winner ? bus.req_addr[ADDRWIDTH +: ADDRWIDTH]
                                     : bus.req_addr[0 +: ADDRWIDTH];
                    strb_d  = winner ? bus.req_strb[7:4] : bus.req_strb[3:0];
                    wdata_d = winner ? bus.req_wdata[63:32] : bus.req_wdata[31:0];
                end
            end
            StSetup: state_d = StAccess;
            StAccess: begin
                state_d = StDone;
                if (!we_q) begin
                    rdata_d = bus.rdata;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            strb_q  <= '0;
            wdata_q <= '0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            strb_q  <= strb_d;
            wdata_q <= wdata_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decode from the registered state so reset clears them asynchronously.
    always_comb begin
        bus.ack         = 2'b00;
        bus.read_en     = 1'b0;
        bus.write_en    = 1'b0;
        bus.addr        = '0;
        bus.byte_strobe = 4'b0000;
        bus.wdata       = '0;
        bus.busy        = (state_q != StIdle);
        unique case (state_q)
            StSetup: begin
                bus.addr        = addr_q;
                bus.wdata       = wdata_q;
                bus.byte_strobe = we_q ? strb_q : 4'b0000;
            end
            StAccess: begin
                bus.addr        = addr_q;
                bus.wdata       = wdata_q;
                bus.byte_strobe = we_q ? strb_q : 4'b0000;
                bus.read_en     = ~we_q;
                bus.write_en    = we_q;
            end
            StDone:  bus.ack = grant_q ? 2'b10 : 2'b01;
            default: ;
        endcase
    end

    assign bus.req_rdata = rdata_q;

    ack_onehot_a: assert property (@(posedge pclk) disable iff (!presetn) $onehot0(bus.ack));
    en_excl_a: assert property (@(posedge pclk) disable iff (!presetn)
                                !(bus.read_en && bus.write_en));

endmodule

// File: tb/tb_apb4_eg_reg_arbiter.sv
// Directed bench: a scoreboard queue holds expected acks, a negedge monitor pops and compares.
// A small register-block model sits on the arbiter's register port.
module tb_apb4_eg_reg_arbiter;

    logic pclk;
    logic presetn;

    apb4_eg_reg_arbiter_if #(.ADDRWIDTH(12)) bus ();

    apb4_eg_reg_arbiter #(.ADDRWIDTH(12)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus.slave)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wen_cnt = 0;
    int          ren_cnt = 0;
    logic [31:0] last_rd = '0;
    logic [31:0] regs [16];

    always @(posedge pclk) cyc <= cyc + 1;

    // Register block: two fixed ID words plus 16 RW words with byte strobes.
    assign bus.rdata = (bus.addr == 12'hFD0) ? 32'h0000_0004 :
                       (bus.addr == 12'hFF4) ? 32'h0000_00F0 :
                       (bus.addr < 12'h040)  ? regs[bus.addr[5:2]] : 32'h0;

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (bus.write_en && bus.addr < 12'h040) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.byte_strobe[b]) regs[bus.addr[5:2]][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge pclk) begin
        exp_t       it;
        logic [1:0] ea;
        if (presetn === 1'b1) begin
            if (bus.write_en) wen_cnt++;
            if (bus.read_en) ren_cnt++;
            if (bus.read_en) chk("read_strobe_zero", bus.byte_strobe, 0);
            if (!bus.busy || bus.ack != 2'b00) begin
                chk("idle_addr_zero", bus.addr, 0);
                chk("idle_wdata_zero", bus.wdata, 0);
                chk("idle_strobe_zero", bus.byte_strobe, 0);
            end
            if (bus.ack != 2'b00) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack 0x%0h, expected none", bus.ack);
                end else begin
                    it = sb.pop_front();
                    ea = (it.idx == 1) ? 2'b10 : 2'b01;
                    chk("ack_grant", bus.ack, ea);
                    chk("ack_rdata", bus.req_rdata, it.rdata);
                    chk("ack_cycle", cyc, it.cyc);
                end
            end
        end
    end

    task automatic step();
        @(negedge pclk);
        #1;
    endtask

    task automatic do_reset();
        step();
        presetn = 1'b0;
        bus.req = 2'b00;
        step();
        chk("rst_ack", bus.ack, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_read_en", bus.read_en, 0);
        chk("rst_write_en", bus.write_en, 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_strobe", bus.byte_strobe, 0);
        chk("rst_wdata", bus.wdata, 0);
        chk("rst_req_rdata", bus.req_rdata, 0);
        step();
        presetn = 1'b1;
        last_rd = '0;
    endtask

    task automatic do_txn(input int idx, input bit we, input logic [11:0] a,
                          input logic [3:0] s, input logic [31:0] d, input logic [31:0] exp);
        int   w0;
        int   r0;
        bit   got;
        exp_t it;
        step();
        w0 = wen_cnt;
        r0 = ren_cnt;
        bus.req_we[idx]            = we;
        bus.req_addr[idx*12 +: 12] = a;
        bus.req_strb[idx*4 +: 4]   = s;
        bus.req_wdata[idx*32 +: 32] = d;
        bus.req = (idx == 1) ? 2'b10 : 2'b01;
        it.idx   = idx;
        it.rdata = we ? last_rd : exp;
        it.cyc   = cyc + 3;
        sb.push_back(it);
        step();
        // Requester lets go right after grant; the latched fields must carry the access.
        bus.req = 2'b00;
        chk("setup_busy", bus.busy, 1);
        chk("setup_addr", bus.addr, a);
        chk("setup_wdata", bus.wdata, d);
        chk("setup_enables", {bus.read_en, bus.write_en}, 0);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            if (bus.ack[idx]) got = 1'b1;
        end
        chk("ack_seen", got, 1);
        step();
        chk("write_en_cycles", wen_cnt - w0, we ? 1 : 0);
        chk("read_en_cycles", ren_cnt - r0, we ? 0 : 1);
        if (!we) last_rd = exp;
    endtask

    initial begin
        int base;
        exp_t it;
        presetn       = 1'b0;
        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_strb  = '0;
        bus.req_wdata = '0;
        repeat (2) step();

        // Partial-strobe write then readback.
        do_reset();
        do_txn(0, 1'b1, 12'h000, 4'b0011, 32'hAABB_CCDD, 32'h0);
        do_txn(0, 1'b0, 12'h000, 4'b1111, 32'h0, 32'h0000_CCDD);

        // Both requesters held high reading the ID words.
        do_reset();
        step();
        bus.req_we   = 2'b00;
        bus.req_addr = {12'hFF4, 12'hFD0};
        bus.req_strb = 8'hFF;
        bus.req      = 2'b11;
        base = cyc;
        for (int k = 0; k < 4; k++) begin
`ifdef APB4_EG_ARB_FIXED_PRIO_EN
            it.idx   = 0;
            it.rdata = 32'h0000_0004;
`else
            it.idx   = k % 2;
            it.rdata = (k % 2 == 1) ? 32'h0000_00F0 : 32'h0000_0004;
`endif
            it.cyc = base + 3 + 4 * k;
            sb.push_back(it);
        end
        repeat (15) step();
        bus.req = 2'b00;
        repeat (4) step();
        chk("sb_drain_contention", sb.size(), 0);
`ifdef APB4_EG_ARB_FIXED_PRIO_EN
        last_rd = 32'h0000_0004;
`else
        last_rd = 32'h0000_00F0;
`endif

        // Reset in the middle of a write access.
        step();
        bus.req_we[0]        = 1'b1;
        bus.req_addr[11:0]   = 12'h004;
        bus.req_strb[3:0]    = 4'hF;
        bus.req_wdata[31:0]  = 32'h55AA_55AA;
        bus.req              = 2'b01;
        step();
        bus.req = 2'b00;
        step();
        chk("abort_write_en_before", bus.write_en, 1);
        presetn = 1'b0;
        #1;
        chk("abort_write_en", bus.write_en, 0);
        chk("abort_read_en", bus.read_en, 0);
        chk("abort_ack", bus.ack, 0);
        chk("abort_busy", bus.busy, 0);
        step();
        step();
        presetn = 1'b1;
        last_rd = '0;
        repeat (4) step();
        chk("abort_idle", bus.busy, 0);

        // Requester 1 write, zero-strobe write, readbacks.
        do_txn(1, 1'b1, 12'h008, 4'hF, 32'h1234_5678, 32'h0);
        do_txn(1, 1'b1, 12'h008, 4'h0, 32'hDEAD_BEEF, 32'h0);
        do_txn(1, 1'b0, 12'h008, 4'hF, 32'h0, 32'h1234_5678);
        do_txn(0, 1'b0, 12'h008, 4'h0, 32'h0, 32'h1234_5678);

        repeat (3) step();
        chk("sb_drain_final", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
